// File: rtl/clk_rst_sequencer.sv
// Reset/lock sequencer: pulses the MMCM reset, qualifies lock, then releases core resets in stages.
// Define CLK_RST_SEQ_LOCK_TIMEOUT_EN to enable the lock timeout, MMCM retry and o_retry_cnt.
module clk_rst_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int MMCM_RST_CYCLES = 16,
  parameter int STABLE_CYCLES   = 1024,
  parameter int LOCK_TIMEOUT    = 65536,
  parameter int NUM_DOMAINS     = 3,
  parameter int STAGE_GAP       = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_locked,
  input  logic                   i_soft_reset,
  output logic                   o_mmcm_reset,
  output logic [NUM_DOMAINS-1:0] o_rst_n,
  output logic                   o_ready,
  output logic [7:0]             o_retry_cnt,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    ST_MMCM_RST  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT      = 3'd5
  } state_t;

  // The WAIT_LOCK cycle that first sees lock_s counts toward the stable window.
  localparam int STABLE_LAST = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0;
  localparam int REL_LAST    = (NUM_DOMAINS - 1) * STAGE_GAP;
  localparam int MAX_A       = (MMCM_RST_CYCLES > STABLE_CYCLES) ? MMCM_RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_B       = (LOCK_TIMEOUT > REL_LAST + 1) ? LOCK_TIMEOUT : REL_LAST + 1;
  localparam int CNT_MAX     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW          = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                   mmcm_q, ready_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) lock_sync <= '0;
    else            lock_sync <= {lock_sync[SYNC_STAGES-2:0], i_locked};
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
  logic       retry_inc;
  logic [7:0] retry_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    rst_n_d = rst_n_q;
`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
    retry_inc = 1'b0;
`endif
    case (state_q)
      ST_MMCM_RST: begin
        if (cnt_q == CW'(MMCM_RST_CYCLES - 1)) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_d = ST_STABLE;
`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
        else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d   = ST_MMCM_RST;
          retry_inc = 1'b1;
        end
`else
        else cnt_d = cnt_q;
`endif
      end
      ST_STABLE: begin
        if (!lock_s)                          state_d = ST_WAIT_LOCK;
        else if (cnt_q == CW'(STABLE_LAST))   state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!lock_s)           state_d = ST_MMCM_RST;
        else if (i_soft_reset) state_d = ST_SOFT;
        else begin
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (cnt_q == CW'(k * STAGE_GAP)) rst_n_d[k] = 1'b1;
          end
          if (cnt_q == CW'(REL_LAST + 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s)           state_d = ST_MMCM_RST;
        else if (i_soft_reset) state_d = ST_SOFT;
      end
      ST_SOFT: begin
        cnt_d = cnt_q;
        if (!lock_s)           state_d = ST_MMCM_RST;
        else if (!i_soft_reset) state_d = ST_RELEASE;
      end
      default: state_d = ST_MMCM_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    // Anything other than staged release or run holds every domain in reset.
    if (state_d != ST_RELEASE && state_d != ST_RUN) rst_n_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_MMCM_RST;
      cnt_q   <= '0;
      rst_n_q <= '0;
      mmcm_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      mmcm_q  <= (state_d == ST_MMCM_RST);
      ready_q <= (state_d == ST_RUN);
    end
  end

`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                         retry_q <= '0;
    else if (retry_inc && retry_q != 8'hff) retry_q <= retry_q + 8'd1;
  end
  assign o_retry_cnt = retry_q;
`else
  assign o_retry_cnt = 8'd0;
`endif

  assign o_mmcm_reset = mmcm_q;
  assign o_rst_n      = rst_n_q;
  assign o_ready      = ready_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer: output edges are scoreboarded against expected cycles.
module tb_clk_rst_sequencer;
  localparam int SYNC_STAGES     = 2;
  localparam int MMCM_RST_CYCLES = 4;
  localparam int STABLE_CYCLES   = 16;
  localparam int LOCK_TIMEOUT    = 64;
  localparam int NUM_DOMAINS     = 3;
  localparam int STAGE_GAP       = 2;
  localparam int REL_LAST        = (NUM_DOMAINS - 1) * STAGE_GAP;
  localparam int W               = 32;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   locked = 1'b0;
  logic                   soft_reset = 1'b0;
  logic                   mmcm_reset;
  logic [NUM_DOMAINS-1:0] rst_n;
  logic                   ready;
  logic [7:0]             retry_cnt;
  logic [2:0]             dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  clk_rst_sequencer #(
    .SYNC_STAGES(SYNC_STAGES), .MMCM_RST_CYCLES(MMCM_RST_CYCLES), .STABLE_CYCLES(STABLE_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT), .NUM_DOMAINS(NUM_DOMAINS), .STAGE_GAP(STAGE_GAP)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_locked(locked), .i_soft_reset(soft_reset),
    .o_mmcm_reset(mmcm_reset), .o_rst_n(rst_n), .o_ready(ready), .o_retry_cnt(retry_cnt),
    .o_dbg_state(dbg_state)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Event word: {code, cycle}. 01/02 mmcm rise/fall, 1k/2k rst_n[k] rise/fall, 30/31 ready rise/fall.
  function automatic logic [W-1:0] ev(input logic [7:0] code, input int c);
    logic [31:0] cv;
    cv = c;
    return {code, cv[23:0]};
  endfunction

  task automatic push_ev(input logic [7:0] code, input int c);
    exp_q.push_back(ev(code, c));
  endtask

  task automatic push_release(input int t0);
    for (int k = 0; k < NUM_DOMAINS; k++) push_ev(8'(8'h10 + k), t0 + k * STAGE_GAP);
    push_ev(8'h30, t0 + REL_LAST + 1);
  endtask

  task automatic push_drop(input int t, input logic with_mmcm);
    if (with_mmcm) push_ev(8'h01, t);
    for (int k = 0; k < NUM_DOMAINS; k++) push_ev(8'(8'h20 + k), t);
    push_ev(8'h31, t);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    int n;
    n = c - cyc;
    if (n > 0) wait_cyc(n);
  endtask

  // Monitor: every output edge must match the head of the scoreboard queue
  logic                   prev_mmcm = 1'b1;
  logic [NUM_DOMAINS-1:0] prev_rst = '0;
  logic                   prev_ready = 1'b0;

  task automatic observe(input logic [7:0] code);
    logic [W-1:0] got;
    got = ev(code, cyc);
    if (exp_q.size() == 0) check("extra_evt", got, '1);
    else                   check("evt", got, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (mmcm_reset !== prev_mmcm) observe(mmcm_reset ? 8'h01 : 8'h02);
    for (int k = 0; k < NUM_DOMAINS; k++)
      if (rst_n[k] !== prev_rst[k]) observe(rst_n[k] ? 8'(8'h10 + k) : 8'(8'h20 + k));
    if (ready !== prev_ready) observe(ready ? 8'h30 : 8'h31);
    prev_mmcm  = mmcm_reset;
    prev_rst   = rst_n;
    prev_ready = ready;
  end

  initial begin
    int r, l, t0, s, d, g, p;
    wait_cyc(3);
    check("rst_mmcm", mmcm_reset, 1);
    check("rst_rst_n", rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_retry", retry_cnt, 0);

    // Power-up
    reset_n = 1'b1;
    r = cyc;
    push_ev(8'h02, r + MMCM_RST_CYCLES);
    wait_cyc(10);
    locked = 1'b1;
    l = cyc;
    t0 = l + SYNC_STAGES + STABLE_CYCLES + 1;
    push_release(t0);
    wait_until(t0 + REL_LAST + 3);
    check("pwr_ready", ready, 1);
    check("pwr_rst_n", rst_n, {NUM_DOMAINS{1'b1}});
    check("pwr_mmcm", mmcm_reset, 0);

    // Soft reset held 5 cycles in RUN
    s = cyc;
    soft_reset = 1'b1;
    push_drop(s + 1, 1'b0);
    wait_cyc(1);
    check("soft_rst_n", rst_n, 0);
    check("soft_ready", ready, 0);
    wait_cyc(4);
    soft_reset = 1'b0;
    push_release(s + 7);
    wait_cyc(2);
    check("soft_mmcm", mmcm_reset, 0);
    wait_until(s + 7 + REL_LAST + 3);
    check("soft_ready_again", ready, 1);

    // Lock loss in RUN
    d = cyc;
    locked = 1'b0;
    push_drop(d + SYNC_STAGES + 1, 1'b1);
    push_ev(8'h02, d + SYNC_STAGES + 1 + MMCM_RST_CYCLES);
    wait_cyc(SYNC_STAGES);
    check("loss_early", rst_n, {NUM_DOMAINS{1'b1}});
    wait_cyc(1);
    check("loss_rst_n", rst_n, 0);
    check("loss_ready", ready, 0);
    check("loss_mmcm", mmcm_reset, 1);
    check("loss_retry", retry_cnt, 0);

    // Glitchy lock: high 10, low 1, high again
    wait_until(d + 10);
    g = cyc;
    locked = 1'b1;
    wait_cyc(10);
    locked = 1'b0;
    wait_cyc(1);
    locked = 1'b1;
    t0 = cyc + SYNC_STAGES + STABLE_CYCLES + 1;
    push_release(t0);
    wait_cyc(STABLE_CYCLES);
    check("glitch_hold", rst_n, 0);
    wait_until(t0 + REL_LAST + 3);
    check("glitch_ready", ready, 1);

    // Async reset while only domain 0 is released
    s = cyc;
    soft_reset = 1'b1;
    push_drop(s + 1, 1'b0);
    wait_cyc(1);
    soft_reset = 1'b0;
    push_ev(8'h10, s + 3);
    wait_cyc(3);
    check("mid_release", rst_n, 1);
    push_ev(8'h01, cyc);
    push_ev(8'h20, cyc);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_n", rst_n, 0);
    check("async_mmcm", mmcm_reset, 1);
    check("async_ready", ready, 0);
    locked = 1'b0;
    wait_cyc(3);

    // Lock never arrives
    reset_n = 1'b1;
    r = cyc;
    push_ev(8'h02, r + MMCM_RST_CYCLES);
`ifdef CLK_RST_SEQ_LOCK_TIMEOUT_EN
    for (int n = 1; n <= 257; n++) begin
      p = r + n * (MMCM_RST_CYCLES + LOCK_TIMEOUT);
      push_ev(8'h01, p);
      push_ev(8'h02, p + MMCM_RST_CYCLES);
    end
    for (int n = 1; n <= 257; n++) begin
      wait_until(r + n * (MMCM_RST_CYCLES + LOCK_TIMEOUT));
      check("retry_cnt", retry_cnt, (n > 255) ? 255 : n);
    end
    wait_cyc(10);
`else
    wait_until(r + 300);
    check("no_timeout_mmcm", mmcm_reset, 0);
    check("no_timeout_retry", retry_cnt, 0);
`endif

    // Final reset clears the retry count
    push_ev(8'h01, cyc);
    #2;
    reset_n = 1'b0;
    #1;
    check("final_mmcm", mmcm_reset, 1);
    check("retry_cleared", retry_cnt, 0);
    wait_cyc(3);
    check("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
